// File: rtl/sprite_line_renderer.sv
// Sprite line renderer: sprite instance table, per-line ROM fetch during blanking,
// and a shadow/active double buffer serialized into a per-pixel "sprite on" stream.
module sprite_line_renderer #(
  parameter  int NUM_SPRITES = 4,
  localparam int SW          = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          table_we,
  input  logic [SW-1:0] table_addr,
  input  logic [25:0]   table_data,
  input  logic          fetch_start,
  input  logic [9:0]    fetch_line,
  input  logic          line_commit,
  input  logic [9:0]    hpos,
  output logic          rom_read_enable,
  output logic [3:0]    rom_sprite_ID,
  output logic [1:0]    rom_orientation,
  output logic [2:0]    rom_line_index,
  input  logic [7:0]    rom_data,
  output logic          fetch_busy,
  output logic          fetch_done,
  output logic          pixel_on,
  output logic [SW-1:0] pixel_slot
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t state, next_state;

  // Sprite table
  logic [9:0] tab_x      [NUM_SPRITES];
  logic [9:0] tab_y      [NUM_SPRITES];
  logic [3:0] tab_id     [NUM_SPRITES];
  logic [1:0] tab_orient [NUM_SPRITES];

  // Shadow (being fetched) and active (being displayed) line buffers
  logic [7:0] shadow_buf [NUM_SPRITES];
  logic [9:0] shadow_x   [NUM_SPRITES];
  logic       shadow_val [NUM_SPRITES];
  logic [7:0] active_buf [NUM_SPRITES];
  logic [9:0] active_x   [NUM_SPRITES];
  logic       active_val [NUM_SPRITES];

  logic [SW-1:0] slot;
  logic [9:0]    line;
  logic [9:0]    dy;
  logic          slot_hit;
  logic          last_slot;

  assign dy        = line - tab_y[slot];
  assign slot_hit  = (dy < 10'd8) && (tab_id[slot] < 4'd9);
  assign last_slot = (slot == SW'(NUM_SPRITES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    unique case (state)
      IDLE:    if (fetch_start) next_state = FETCH;
      FETCH:   if (last_slot)   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: ROM request is driven only while a hitting slot is visited
  always_comb begin
    fetch_busy      = (state == FETCH);
    fetch_done      = (state == DONE);
    rom_read_enable = 1'b0;
    rom_sprite_ID   = 4'd0;
    rom_orientation = 2'd0;
    rom_line_index  = 3'd0;
    if (state == FETCH && slot_hit) begin
      rom_read_enable = 1'b1;
      rom_sprite_ID   = tab_id[slot];
      rom_orientation = tab_orient[slot];
      rom_line_index  = dy[2:0];
    end
  end

  // Slot counter and latched line
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      slot <= '0;
      line <= '0;
    end else if (state == IDLE && fetch_start) begin
      slot <= '0;
      line <= fetch_line;
    end else if (state == FETCH && !last_slot) begin
      slot <= slot + 1'b1;
    end
  end

  // Table, shadow and active buffers
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these arrays are small flops with a defined reset value, so they are reset, unlike RAM.
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tab_x[i]      <= '0;
        tab_y[i]      <= '0;
        tab_id[i]     <= 4'hF;
        tab_orient[i] <= '0;
        shadow_buf[i] <= '0;
        shadow_x[i]   <= '0;
        shadow_val[i] <= 1'b0;
        active_buf[i] <= '0;
        active_x[i]   <= '0;
        active_val[i] <= 1'b0;
      end
    end else begin
      if (table_we)
        {tab_x[table_addr], tab_y[table_addr], tab_id[table_addr], tab_orient[table_addr]}
          <= table_data;

      if (state == FETCH) begin
        if (slot_hit) begin
          shadow_buf[slot] <= ~rom_data;
          shadow_x[slot]   <= tab_x[slot];
          shadow_val[slot] <= 1'b1;
        end else begin
          shadow_val[slot] <= 1'b0;
        end
      end

      // Commit copies pre-edge shadow contents; same-edge shadow writes land next line
      if (line_commit) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          active_buf[i] <= shadow_buf[i];
          active_x[i]   <= shadow_x[i];
          active_val[i] <= shadow_val[i];
        end
      end
    end
  end

  // Display: per-slot offset, lowest-numbered lit slot wins
  logic [9:0]    disp_dx [NUM_SPRITES];
  logic          lit_any;
  logic [SW-1:0] lit_slot;

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++)
      disp_dx[i] = hpos - active_x[i];
  end

  always_comb begin
    lit_any  = 1'b0;
    lit_slot = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (active_val[i] && disp_dx[i] < 10'd8 && active_buf[i][~disp_dx[i][2:0]]) begin
        lit_any  = 1'b1;
        lit_slot = SW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_on   <= 1'b0;
      pixel_slot <= '0;
    end else begin
      pixel_on   <= lit_any;
      pixel_slot <= lit_slot;
    end
  end

endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Consumer side of the sprite ROM read interface: holds a small table of sprite instances, fetches one 8-pixel line per on-line sprite from the sprite ROM during horizontal blanking, and serializes the buffered lines into a per-pixel "sprite on" stream aligned to the VGA horizontal counter. It sits between the game-state logic (table writes), the sprite ROM (line reads) and the pixel colour mux.

## Interface
- NUM_SPRITES, 4, number of sprite table slots; legal values are 1 to 8; the slot index width is SW = max(1, clog2(NUM_SPRITES)).
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- table_we  in  1  write strobe for the sprite table.
- table_addr  in  SW  slot to write.
- table_data  in  26  the slot entry: {x[9:0], y[9:0], sprite_ID[3:0], orientation[1:0]}, MSB first.
- fetch_start  in  1  single-cycle pulse that starts fetching for line fetch_line.
- fetch_line  in  10  vertical line to fetch; sampled on fetch_start.
- line_commit  in  1  single-cycle pulse that copies the shadow buffers into the active buffers.
- hpos  in  10  current horizontal pixel position.
- rom_read_enable  out  1  ROM read strobe (combinational).
- rom_sprite_ID  out  4  ROM sprite select (combinational).
- rom_orientation  out  2  ROM orientation select (combinational).
- rom_line_index  out  3  ROM line select (combinational).
- rom_data  in  8  ROM line data; combinational, valid in the same cycle; active-low (0 = pixel on).
- fetch_busy  out  1  high while in FETCH.
- fetch_done  out  1  one-cycle pulse after the last slot has been fetched.
- pixel_on  out  1  registered: a sprite pixel is lit at the previous cycle's hpos.
- pixel_slot  out  SW  registered: the slot that owns pixel_on; 0 when pixel_on = 0.

## Operation
- **Sprite table.** The table has NUM_SPRITES entries.
  - Reset sets every entry's sprite_ID to 4'hF (empty); all other fields reset to 0.
  - An entry whose sprite_ID is 9 or greater is empty and never produces pixels.
- **FSM states.** IDLE, FETCH, DONE.
  - IDLE to FETCH on fetch_start: latch fetch_line as L and clear the slot counter s. fetch_start is ignored outside IDLE.
  - FETCH: one slot per cycle.
    - dy = (L - y[s]) mod 1024. The slot hits when dy < 8 and the entry is non-empty.
    - On a hit: rom_read_enable = 1, rom_sprite_ID = ID[s], rom_orientation = orient[s], rom_line_index = dy[2:0]. The shadow buffer shadow[s] takes ~rom_data (active-high) at the clock edge, and the shadow x and valid bit for slot s are updated.
    - On a miss: rom_read_enable = 0, all rom_* outputs = 0, and shadow valid[s] is cleared.
    - Table fields are read at the slot's visit. A table write to slot s on the same edge it is visited is not seen by this fetch.
    - s = NUM_SPRITES-1 moves to DONE.
  - DONE: fetch_done = 1 for one cycle, then return to IDLE.
- **Commit.** On line_commit, the active buffers, active x values and active valid bits take the shadow values present before that edge. line_commit works in any state and can coincide with fetch_start or with FETCH writes; shadow writes on the same edge are not committed.
- **Display.** For each active slot i, dx = (hpos - xa[i]) mod 1024. The slot is lit when valid[i] = 1, dx < 8, and buf[i][7 - dx] = 1 (bit 7 is the leftmost pixel).
  - The lowest-numbered lit slot wins.
  - pixel_on and pixel_slot are registered from this result.
- **Wrap-around.** Positions wrap modulo 1024. For example, x = 1020 lights hpos 1020 to 1023 and 0 to 3.
- **Reset.** Reset at any time, including mid-FETCH:
  - state returns to IDLE;
  - all shadow and active valid bits and buffers are cleared;
  - all outputs go to 0.

## Timing
- Fetch latency: fetch_start at cycle T gives fetch_busy = 1 for cycles T+1 to T+NUM_SPRITES, and fetch_done = 1 at T+NUM_SPRITES+1.
- Back-to-back fetches: the earliest accepted next fetch_start is at cycle T+NUM_SPRITES+2.
- ROM inputs are sampled at the end of the same FETCH cycle; there are no wait states.
- Pixel latency: 1 cycle from hpos to pixel_on and pixel_slot.
- A commit affects pixel_on starting at the hpos presented in the cycle after line_commit.

## Test plan
- **Basic fetch and display.** Slot 0 = {x=100, y=50, ID=0 heart, UP}; fetch line 52, then commit. Require: rom_line_index = 2 during the slot-0 FETCH cycle; pixel_on = 1 for hpos 100..107 (ROM row 00000000); pixel_on = 0 at hpos 99 and 108; fetch_done at T+5.
- **Miss and empty slots.** Slot 1 has y=60 and the fetch is for line 52; slot 2 has ID=4'hF. Require: rom_read_enable = 0 in both of those cycles and no pixels from slots 1 or 2.
- **Priority.** Slots 0 and 3 overlap at the same x. Require: pixel_slot = 0 wherever both are lit, and pixel_slot = 3 where only slot 3 is lit.
- **Wrap-around.** x = 1020 with a sword (ID 1) on line y+0 (row 11101111). Require: pixel_on only at hpos 1023.
- **Commit isolation.** Fetch new content without line_commit. Require: the old line is still displayed. After line_commit, the new line is displayed from the next hpos.
- **Reset mid-fetch.** Assert reset at T+2 of a fetch. Require: fetch_busy = 0, no fetch_done pulse, and pixel_on = 0 after a subsequent commit.
